// File: rtl/spike_event_fifo.sv
// Double-buffered spike tag FIFO: the neuron-update stage fills one bank while the
// compute-in-memory stage drains the other; a swap pulse exchanges the two banks.
module spike_event_fifo #(
    parameter int TAG_W = 1,
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             asyn_reset,
    input  logic             enq,
    input  logic [TAG_W-1:0] enq_tag,
    output logic             full,
    input  logic             swap,
    input  logic             req_deq,
    output logic             fifo_empty,
    output logic [TAG_W-1:0] fired_tag,
    output logic [CNT_W-1:0] rd_count,
    output logic [CNT_W-1:0] wr_count,
    output logic             bank_sel,
    output logic             overflow,
    output logic             lost_events
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);
    localparam logic [PTR_W-1:0] P_ONE = PTR_W'(1);

    logic                   r_bank_sel;
    logic                   r_overflow;
    logic                   r_lost;
    logic [TAG_W-1:0]       r_mem [2*DEPTH];

    logic [1:0][PTR_W-1:0]  w_rd_ptr;
    logic [1:0][PTR_W-1:0]  w_wr_ptr;
    logic [1:0][CNT_W-1:0]  w_cnt;
    logic                   w_rd_bank;
    logic                   w_do_enq;
    logic                   w_do_deq;
    logic [CNT_W-1:0]       w_rd_left;

    assign w_rd_bank  = ~r_bank_sel;
    assign wr_count   = w_cnt[r_bank_sel];
    assign rd_count   = w_cnt[w_rd_bank];
    assign full       = (wr_count == CNT_W'(DEPTH));
    assign fifo_empty = (rd_count == '0);
    assign w_do_enq   = enq && !full;
    assign w_do_deq   = req_deq && !fifo_empty;
    // Entries still unread in the outgoing read bank once a same-edge pop is applied.
    assign w_rd_left  = rd_count - (w_do_deq ? C_ONE : '0);

    assign fired_tag   = fifo_empty ? '0 : r_mem[{w_rd_bank, w_rd_ptr[w_rd_bank]}];
    assign bank_sel    = r_bank_sel;
    assign overflow    = r_overflow;
    assign lost_events = r_lost;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_bank
            logic             w_is_wr;
            logic [PTR_W-1:0] r_rd_ptr;
            logic [PTR_W-1:0] r_wr_ptr;
            logic [CNT_W-1:0] r_cnt;

            assign w_is_wr     = (r_bank_sel == 1'(gi));
            assign w_rd_ptr[gi] = r_rd_ptr;
            assign w_wr_ptr[gi] = r_wr_ptr;
            assign w_cnt[gi]    = r_cnt;

            // A write bank keeps its contents across a swap; a read bank is emptied by it.
            always_ff @(posedge clk or negedge asyn_reset) begin
                if (!asyn_reset) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_cnt    <= '0;
                end else if (w_is_wr) begin
                    if (w_do_enq) begin
                        r_wr_ptr <= r_wr_ptr + P_ONE;
                        r_cnt    <= r_cnt + C_ONE;
                    end
                end else if (swap) begin
                    r_rd_ptr <= '0;
                    r_wr_ptr <= '0;
                    r_cnt    <= '0;
                end else if (w_do_deq) begin
                    r_rd_ptr <= r_rd_ptr + P_ONE;
                    r_cnt    <= r_cnt - C_ONE;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge asyn_reset) begin
        if (!asyn_reset) begin
            r_bank_sel <= 1'b0;
            r_overflow <= 1'b0;
            r_lost     <= 1'b0;
        end else begin
            if (swap)
                r_bank_sel <= ~r_bank_sel;
            if (enq && full)
                r_overflow <= 1'b1;
            if (swap && (w_rd_left != '0))
                r_lost <= 1'b1;
        end
    end

    // Storage is never cleared; the empty check on fired_tag hides stale contents.
    always_ff @(posedge clk) begin
        if (w_do_enq && asyn_reset)
            r_mem[{r_bank_sel, w_wr_ptr[r_bank_sel]}] <= enq_tag;
    end

endmodule

// File: doc/spike_event_fifo.md
SPIKE_EVENT_FIFO -- requirements
Module: spike_event_fifo

Interface
REQ-001 Parameter TAG_W, default 1: width of one fired-neuron tag.
REQ-002 Parameter DEPTH, default 4: entries per bank, power of two >= 2.
REQ-003 Parameter CNT_W, default 3: occupancy counter width, log2(DEPTH)+1.
REQ-004 clk  input  1  single clock, all state updates on rising edge.
REQ-005 asyn_reset  input  1  asynchronous, active-low reset.
REQ-006 enq  input  1  write request from the neuron-update stage: push enq_tag into the write bank.
REQ-007 enq_tag  input  TAG_W  tag of a neuron that fired this timestep.
REQ-008 full  output  1  write bank holds DEPTH entries.
REQ-009 swap  input  1  timestep boundary pulse; exchanges the write and read banks.
REQ-010 req_deq  input  1  pop request from the compute-in-memory stage.
REQ-011 fifo_empty  output  1  read bank holds 0 entries.
REQ-012 fired_tag  output  TAG_W  head of the read bank (show-ahead).
REQ-013 rd_count  output  CNT_W  read-bank occupancy.
REQ-014 wr_count  output  CNT_W  write-bank occupancy.
REQ-015 bank_sel  output  1  index of the current write bank; the read bank is !bank_sel.
REQ-016 overflow  output  1  sticky: an enq was dropped because the write bank was full.
REQ-017 lost_events  output  1  sticky: a swap discarded unread read-bank entries.

Function
REQ-018 Storage: two banks of DEPTH x TAG_W, each with its own read pointer, write pointer and count; pointers wrap modulo DEPTH.
REQ-019 enq with !full: store enq_tag at the write-bank write pointer, advance the pointer, wr_count+1, all at the same edge.
REQ-020 enq with full: drop the entry, leave pointers and count unchanged, set overflow at that edge.
REQ-021 fired_tag is combinational from the read-bank head entry; it is all-zeros whenever fifo_empty=1.
REQ-022 req_deq with !fifo_empty: advance the read-bank read pointer and decrement rd_count; the next entry appears on fired_tag the following cycle.
REQ-023 req_deq with fifo_empty: ignored; no state change and no error flag.
REQ-024 Deq-to-deq throughput is one pop per cycle; enq throughput is one push per cycle; enq and deq are independent because they address different banks.
REQ-025 swap (one-cycle pulse) at edge N: bank_sel toggles.
REQ-026 After that swap, the old write bank, including any enq accepted at edge N, becomes the read bank with its count unchanged.
REQ-027 After that swap, the old read bank becomes the write bank with its pointers and count cleared to 0.
REQ-028 swap while rd_count != 0 (after any same-edge deq is applied): the remaining entries are discarded and lost_events is set.
REQ-029 swap+enq in the same cycle: the entry lands in the bank that becomes the read bank; if that bank was full, the entry is dropped and overflow is set.
REQ-030 swap+req_deq in the same cycle: the pop applies to the outgoing read bank before it is cleared; lost_events is set only if entries remain after the pop.
REQ-031 swap held high for k cycles: one toggle per cycle; no edge detection.
REQ-032 full = (wr_count == DEPTH); fifo_empty = (rd_count == 0); both are combinational from the registered counts.
REQ-033 Flags: overflow and lost_events are cleared only by reset.

Reset
REQ-034 asyn_reset low: immediately clear all pointers and counts, bank_sel=0, overflow=0, lost_events=0.
REQ-035 Output values during reset: fifo_empty=1, full=0, fired_tag=0, rd_count=0, wr_count=0.
REQ-036 Bank storage contents need not be cleared; outputs must not expose stale data while empty.
REQ-037 Reset asserted mid-burst: all in-flight enq, deq and swap are abandoned with no partial update.
REQ-038 Reset release: the first operation is taken at the first rising edge with asyn_reset high.

Verification (TAG_W=4, DEPTH=4)
REQ-039 Reset, then idle 2 cycles -> fifo_empty=1, full=0, fired_tag=0, bank_sel=0, both counts 0.
REQ-040 enq tags 3,5,9 on consecutive cycles, then swap -> bank_sel=1, rd_count=3, fired_tag=3; req_deq on 3 cycles -> fired_tag 5, 9, then fifo_empty=1 with fired_tag=0.
REQ-041 enq 5 tags without swap -> full=1 after the 4th; 5th dropped, overflow=1; after swap, rd_count=4.
REQ-042 After REQ-040, enq 7 with swap in the same cycle -> tag 7 readable after the swap, rd_count=1, lost_events=0.
REQ-043 Read bank holds 2 entries; assert req_deq and swap together -> one popped, one discarded, lost_events=1, new read bank holds the prior write-bank contents.
REQ-044 asyn_reset low mid-stream with both banks non-empty, without a clock edge -> all outputs reach their reset values asynchronously; first enq after release lands in bank 0.
